// File: rtl/iob_div_subshift.sv
// Shift-subtract divider: one restoring step per enabled clock, DATA_W+4 enabled edges to done.
// No reset; holding en low for one edge clears pc, done and the working register.
module iob_div_subshift #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              en,
  input  logic              sign,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              done
);
  localparam int PC_W = $clog2(DATA_W + 4);
  localparam logic [PC_W-1:0] LAST_STEP = PC_W'(DATA_W);
  localparam logic [PC_W-1:0] Q_FIX     = PC_W'(DATA_W + 1);
  localparam logic [PC_W-1:0] R_FIX     = PC_W'(DATA_W + 2);

  logic [PC_W-1:0]     pc;
  logic [2*DATA_W-1:0] rq;
  logic [DATA_W-1:0]   dvs;
  logic                q_neg, r_neg;
  logic [2*DATA_W:0]   sh;
  logic [DATA_W:0]     diff;
  logic [2*DATA_W-1:0] step;
  logic [DATA_W-1:0]   dvd_abs, dvs_abs;

  assign dvd_abs = (sign && dividend[DATA_W-1]) ? -dividend : dividend;
  assign dvs_abs = (sign && divisor[DATA_W-1])  ? -divisor  : divisor;

  // Shifted partial remainder needs DATA_W+1 bits; diff MSB set means no subtract.
  always_comb begin
    sh   = {rq, 1'b0};
    diff = sh[2*DATA_W:DATA_W] - {1'b0, dvs};
    step = diff[DATA_W] ? sh[2*DATA_W-1:0]
                        : {diff[DATA_W-1:0], sh[DATA_W-1:1], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (!en) begin
      pc   <= '0;
      done <= 1'b0;
      rq   <= '0;
    end else if (pc == '0) begin
      rq    <= {{DATA_W{1'b0}}, dvd_abs};
      dvs   <= dvs_abs;
      q_neg <= sign && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
      r_neg <= sign && dividend[DATA_W-1];
      pc    <= pc + 1'b1;
    end else if (pc <= LAST_STEP) begin
      rq <= step;
      pc <= pc + 1'b1;
    end else if (pc == Q_FIX) begin
      if (q_neg) rq[DATA_W-1:0] <= -rq[DATA_W-1:0];
      pc <= pc + 1'b1;
    end else if (pc == R_FIX) begin
      if (r_neg) rq[2*DATA_W-1:DATA_W] <= -rq[2*DATA_W-1:DATA_W];
      pc <= pc + 1'b1;
    end else begin
      done <= 1'b1;
    end
  end

  assign quotient  = rq[DATA_W-1:0];
  assign remainder = rq[2*DATA_W-1:DATA_W];
endmodule

// File: rtl/iob_div_ctrl.sv
// Divider sequencer: latches operands, runs iob_div_subshift, holds the result until out_ready.
// Divide-by-zero and signed MIN/-1 bypass the divider and complete one cycle after acceptance.
module iob_div_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [DATA_W-1:0] in_dividend,
  input  logic [DATA_W-1:0] in_divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_quotient,
  output logic [DATA_W-1:0] out_remainder,
  output logic              out_div_zero,
  output logic              out_ovf
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  localparam logic [DATA_W-1:0] ALL_ONES = '1;
  localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};

  logic [1:0]        state, state_nxt;
  logic              op_sign, fast_pend, accept, in_special, op_zero, op_ovf;
  logic [DATA_W-1:0] op_dividend, op_divisor;
  logic              div_en, div_done;
  logic [DATA_W-1:0] div_q, div_r;

  assign accept     = in_valid && in_ready;
  assign in_special = (in_divisor == '0) ||
                      (in_sign && in_dividend == MIN_NEG && in_divisor == ALL_ONES);
  assign op_zero    = (op_divisor == '0);
  assign op_ovf     = op_sign && op_dividend == MIN_NEG && op_divisor == ALL_ONES;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A special-case operand spends one IDLE cycle with in_ready low, so en never rises for it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (fast_pend) state_nxt = HOLD;
            else if (accept && !in_special) state_nxt = RUN;
      RUN:  if (div_done) state_nxt = HOLD;
      HOLD: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !fast_pend;
    out_valid = (state == HOLD);
    div_en    = (state == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fast_pend   <= 1'b0;
      op_sign     <= 1'b0;
      op_dividend <= '0;
      op_divisor  <= '0;
    end else begin
      fast_pend <= accept && in_special;
      if (accept) begin
        op_sign     <= in_sign;
        op_dividend <= in_dividend;
        op_divisor  <= in_divisor;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_quotient  <= '0;
      out_remainder <= '0;
      out_div_zero  <= 1'b0;
      out_ovf       <= 1'b0;
    end else if (state == IDLE && fast_pend) begin
      out_div_zero  <= op_zero;
      out_ovf       <= !op_zero && op_ovf;
      out_quotient  <= op_zero ? ALL_ONES : op_dividend;
      out_remainder <= op_zero ? op_dividend : '0;
    end else if (accept) begin
      out_div_zero <= 1'b0;
      out_ovf      <= 1'b0;
    end else if (state == RUN && div_done) begin
      out_quotient  <= div_q;
      out_remainder <= div_r;
    end
  end

  iob_div_subshift #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .en        (div_en),
    .sign      (op_sign),
    .dividend  (op_dividend),
    .divisor   (op_divisor),
    .quotient  (div_q),
    .remainder (div_r),
    .done      (div_done)
  );
endmodule

// File: tb/tb_iob_div_ctrl.sv
// Bench for iob_div_ctrl: vector table, randomized ops against an arithmetic model, backpressure and reset sequences.
module tb_iob_div_ctrl;
  localparam int W = 32;
  localparam int NORM_LAT = W + 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_sign, out_valid, out_ready;
  logic [W-1:0] in_dividend, in_divisor, out_quotient, out_remainder;
  logic         out_div_zero, out_ovf;

  int n_tests = 0;
  int n_fail  = 0;
  int en_cnt  = 0;

  always #5 clk = ~clk;

  iob_div_ctrl #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder),
    .out_div_zero(out_div_zero), .out_ovf(out_ovf)
  );

  always @(negedge clk) if (dut.div_en === 1'b1) en_cnt <= en_cnt + 1;

  typedef struct {
    bit           sgn;
    logic [W-1:0] a, b, q, r;
    bit           dz, ovf;
    int           lat;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void model(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output bit dz, output bit ovf, output int lat);
    int sa, sb;
    dz = 0; ovf = 0; lat = 1;
    if (b == 0) begin
      q = '1; r = a; dz = 1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a; r = '0; ovf = 1;
    end else if (sgn) begin
      sa = a; sb = b;
      q = W'(sa / sb); r = W'(sa % sb); lat = NORM_LAT;
    end else begin
      q = a / b; r = a % b; lat = NORM_LAT;
    end
  endfunction

  task automatic run_op(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic dz, output logic ovf, output int lat, output int encnt);
    int guard = 0;
    int e0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    in_valid = 1'b1; in_sign = sgn; in_dividend = a; in_divisor = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e0 = en_cnt;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    q = out_quotient; r = out_remainder; dz = out_div_zero; ovf = out_ovf;
    encnt = en_cnt - e0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_op(input string tag, input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q, r, eq, er;
    logic dz, ovf;
    bit edz, eovf;
    int lat, elat, encnt;
    model(sgn, a, b, eq, er, edz, eovf, elat);
    run_op(sgn, a, b, q, r, dz, ovf, lat, encnt);
    chk({tag, "_q"}, q, eq);
    chk({tag, "_r"}, r, er);
    chk({tag, "_flags"}, {30'd0, dz, ovf}, {30'd0, edz, eovf});
    chk({tag, "_lat"}, W'(lat), W'(elat));
    chk({tag, "_en_cycles"}, W'(encnt), (elat == 1) ? '0 : W'(NORM_LAT));
  endtask

  initial begin
    vec_t vecs[$];
    logic [W-1:0] q, r, a, b, q0, r0;
    logic dz, ovf;
    int lat, encnt, bad, mode;
    bit sgn;

    rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_dividend = '0; in_divisor = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_q", out_quotient, '0);
    chk("rst_r", out_remainder, '0);
    chk("rst_flags", {30'd0, out_div_zero, out_ovf}, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    // sgn, dividend, divisor, quotient, remainder, div_zero, ovf, latency
    vecs.push_back('{0, 32'd100,        32'd7,        32'd14,         32'd2,          0, 0, 37});
    vecs.push_back('{1, 32'hFFFF_FFF9,  32'd2,        32'hFFFF_FFFD,  32'hFFFF_FFFF,  0, 0, 37});
    vecs.push_back('{1, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,          0, 0, 37});
    vecs.push_back('{1, 32'hFFFF_FF9C,  32'd7,        32'hFFFF_FFF2,  32'hFFFF_FFFE,  0, 0, 37});
    vecs.push_back('{0, 32'h0000_1234,  32'd0,        32'hFFFF_FFFF,  32'h0000_1234,  1, 0, 1});
    vecs.push_back('{1, 32'h0000_1234,  32'd0,        32'hFFFF_FFFF,  32'h0000_1234,  1, 0, 1});
    vecs.push_back('{1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,          0, 1, 1});
    vecs.push_back('{0, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000,  0, 0, 37});
    vecs.push_back('{1, 32'h8000_0000,  32'd0,        32'hFFFF_FFFF,  32'h8000_0000,  1, 0, 1});
    vecs.push_back('{0, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF,  32'd0,          0, 0, 37});
    vecs.push_back('{0, 32'd0,          32'd5,        32'd0,          32'd0,          0, 0, 37});

    foreach (vecs[i]) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, q, r, dz, ovf, lat, encnt);
      chk($sformatf("vec%0d_q", i), q, vecs[i].q);
      chk($sformatf("vec%0d_r", i), r, vecs[i].r);
      chk($sformatf("vec%0d_flags", i), {30'd0, dz, ovf}, {30'd0, vecs[i].dz, vecs[i].ovf});
      chk($sformatf("vec%0d_lat", i), W'(lat), W'(vecs[i].lat));
      chk($sformatf("vec%0d_en", i), W'(encnt), (vecs[i].lat == 1) ? '0 : W'(NORM_LAT));
    end

    for (int i = 0; i < 30; i++) begin
      mode = $urandom_range(0, 7);
      sgn = 1'($urandom);
      a = $urandom; b = $urandom;
      if (mode == 0) b = '0;
      else if (mode == 1) begin a = 32'h8000_0000; b = '1; end
      else if (mode == 2) b = W'($urandom_range(1, 300));
      check_op($sformatf("rnd%0d", i), sgn, a, b);
    end

    // Backpressure: result held while in_valid keeps offering new operands.
    in_valid = 1'b1; in_sign = 1'b0; in_dividend = 32'd100; in_divisor = 32'd7;
    @(posedge clk); #1;
    in_dividend = 32'd55; in_divisor = 32'd3;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
      in_dividend = $urandom; in_divisor = $urandom;
    end
    chk("bp_lat", W'(lat), W'(NORM_LAT));
    q0 = out_quotient; r0 = out_remainder;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (!out_valid || in_ready || out_quotient !== q0 || out_remainder !== r0) bad++;
      in_dividend = $urandom; in_divisor = $urandom;
    end
    chk("bp_q", q0, 32'd14);
    chk("bp_r", r0, 32'd2);
    chk("bp_stable_cycles_bad", W'(bad), '0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    check_op("bp_next", 1'b1, 32'hFFFF_FFF9, 32'd2);

    // Asynchronous reset in the middle of a divider run.
    in_valid = 1'b1; in_sign = 1'b0; in_dividend = 32'd1000; in_divisor = 32'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_run_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_run_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_op("after_rst", 1'b0, 32'd100, 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
